// File: rtl/kvs_ctrl_pkg.sv
// Shared types for the KVS kernel controller.
// State encoding and channel-count ceiling live here.
package kvs_ctrl_pkg;

  localparam int unsigned KVS_MAX_CH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE,
    ST_WAIT_CONT
  } kvs_ctrl_state_t;

endpackage

// File: rtl/kvs_done_collector.sv
// Channel mask latch and sticky per-channel done collector.
// all_done looks through to this cycle's ch_done so completion costs no extra cycle.
module kvs_done_collector #(
  parameter int C_NUM_CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      clear,
  input  logic                      capture,
  input  logic [C_NUM_CHANNELS-1:0] ch_enable,
  input  logic [C_NUM_CHANNELS-1:0] ch_done,
  output logic [C_NUM_CHANNELS-1:0] mask,
  output logic                      all_done
);

  logic [C_NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [C_NUM_CHANNELS-1:0] col_q, col_d;
  logic [C_NUM_CHANNELS-1:0] done_in;

  always_comb begin
    mask_d  = mask_q;
    col_d   = col_q;
    done_in = capture ? ch_done : '0;
    if (load) begin
      mask_d = ch_enable;
    end
    // channels left out of the run count as already finished
    if (clear) begin
      col_d = ~mask_q;
    end else if (capture) begin
      col_d = col_q | done_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      col_q  <= '0;
    end else begin
      mask_q <= mask_d;
      col_q  <= col_d;
    end
  end

  assign mask     = mask_q;
  assign all_done = &(col_q | done_in);

endmodule

// File: rtl/kvs_kernel_ctrl.sv
// ap_ctrl_hs / ap_ctrl_chain block controller fanning a start out to N channels.
// Tracks run length, optional watchdog, and waits for every enabled channel.
module kvs_kernel_ctrl
  import kvs_ctrl_pkg::*;
#(
  parameter int C_NUM_CHANNELS    = 4,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_CHAIN_MODE      = 0,
  parameter int C_CNT_WIDTH       = 48,
  parameter int C_TIMEOUT_CYCLES  = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  input  logic                         ap_continue,
  output logic                         ap_idle,
  output logic                         ap_ready,
  output logic                         ap_done,
  input  logic [C_XFER_SIZE_WIDTH-1:0] data_num,
  output logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size,
  input  logic [C_NUM_CHANNELS-1:0]    ch_enable,
  output logic [C_NUM_CHANNELS-1:0]    ch_start,
  input  logic [C_NUM_CHANNELS-1:0]    ch_done,
  output logic [C_CNT_WIDTH-1:0]       busy_cycles,
  output logic                         timeout
);

  localparam logic [C_CNT_WIDTH-1:0] TMO_LIM =
    C_CNT_WIDTH'(C_TIMEOUT_CYCLES);
  localparam logic [C_CNT_WIDTH-1:0] ONE = C_CNT_WIDTH'(1);

  kvs_ctrl_state_t state_q, state_d;

  logic                         start_r_q;
  logic                         armed_q, armed_d;
  logic [C_XFER_SIZE_WIDTH-1:0] xfer_q, xfer_d;
  logic [C_CNT_WIDTH-1:0]       busy_q, busy_d;
  logic                         tmo_q, tmo_d;

  logic                         start_edge;
  logic                         launch;
  logic [C_NUM_CHANNELS-1:0]    mask;
  logic                         all_done;

  assign start_edge = ap_start & ~start_r_q;
  // a start held across reset must be seen low once before it counts
  assign armed_d    = armed_q | ~ap_start;
  assign launch     = (state_q == ST_IDLE) & start_edge & armed_q;

  kvs_done_collector #(
    .C_NUM_CHANNELS(C_NUM_CHANNELS)
  ) u_collector (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .load     (launch),
    .clear    (state_q == ST_LAUNCH),
    .capture  (state_q == ST_RUN),
    .ch_enable(ch_enable),
    .ch_done  (ch_done),
    .mask     (mask),
    .all_done (all_done)
  );

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    busy_d  = busy_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_LAUNCH;
          xfer_d  = data_num;
          busy_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
        busy_d  = '0;
        tmo_d   = 1'b0;
      end
      ST_RUN: begin
        if (busy_q != '1) begin
          busy_d = busy_q + ONE;
        end
        if (all_done) begin
          state_d = ST_DONE;
        end
        if (C_TIMEOUT_CYCLES > 0 && busy_d == TMO_LIM) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (C_CHAIN_MODE == 0 || ap_continue) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_CONT;
        end
      end
      ST_WAIT_CONT: begin
        if (ap_continue) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      start_r_q <= 1'b0;
      armed_q   <= 1'b0;
      xfer_q    <= '0;
      busy_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_r_q <= ap_start;
      armed_q   <= armed_d;
      xfer_q    <= xfer_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
    end
  end

  assign ap_idle        = (state_q == ST_IDLE);
  assign ap_ready       = (state_q == ST_LAUNCH);
  assign ap_done        = (state_q == ST_DONE) |
                          (state_q == ST_WAIT_CONT);
  assign ch_start       = ap_ready ? mask : '0;
  assign ctrl_xfer_size = xfer_q;
  assign busy_cycles    = busy_q;
  assign timeout        = tmo_q;

endmodule

// File: tb/tb_kvs_kernel_ctrl.sv
// Bench for kvs_kernel_ctrl: handshake instance with watchdog plus a chain-mode instance.
// Expected values come from the protocol rules; random runs use a completion-time model.
module tb_kvs_kernel_ctrl;

  localparam int N  = 4;
  localparam int XW = 32;
  localparam int CW = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_start, a_cont, a_idle, a_ready, a_done, a_tmo;
  logic [XW-1:0] a_num, a_xfer;
  logic [N-1:0]  a_en, a_cstart, a_cdone;
  logic [CW-1:0] a_busy;

  logic          b_start, b_cont, b_idle, b_ready, b_done, b_tmo;
  logic [XW-1:0] b_num, b_xfer;
  logic [N-1:0]  b_en, b_cstart, b_cdone;
  logic [CW-1:0] b_busy;

  int checks = 0;
  int failures = 0;

  kvs_kernel_ctrl #(
    .C_NUM_CHANNELS(N), .C_XFER_SIZE_WIDTH(XW), .C_CHAIN_MODE(0),
    .C_CNT_WIDTH(CW), .C_TIMEOUT_CYCLES(100)
  ) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(a_start),
    .ap_continue(a_cont), .ap_idle(a_idle), .ap_ready(a_ready),
    .ap_done(a_done), .data_num(a_num), .ctrl_xfer_size(a_xfer),
    .ch_enable(a_en), .ch_start(a_cstart), .ch_done(a_cdone),
    .busy_cycles(a_busy), .timeout(a_tmo)
  );

  kvs_kernel_ctrl #(
    .C_NUM_CHANNELS(N), .C_XFER_SIZE_WIDTH(XW), .C_CHAIN_MODE(1),
    .C_CNT_WIDTH(CW), .C_TIMEOUT_CYCLES(0)
  ) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(b_start),
    .ap_continue(b_cont), .ap_idle(b_idle), .ap_ready(b_ready),
    .ap_done(b_done), .data_num(b_num), .ctrl_xfer_size(b_xfer),
    .ch_enable(b_en), .ch_start(b_cstart), .ch_done(b_cdone),
    .busy_cycles(b_busy), .timeout(b_tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_start = 1'b1; a_cont = 1'b0; a_num = '0; a_en = '0; a_cdone = '0;
    b_start = 1'b0; b_cont = 1'b0; b_num = '0; b_en = '0; b_cdone = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    checks++;
    if ({a_idle, a_ready, a_done, a_tmo} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 1000",
               {a_idle, a_ready, a_done, a_tmo});
    end
    checks++;
    if (a_cstart !== '0 || a_xfer !== '0 || a_busy !== '0) begin
      failures++;
      $display("FAIL reset_data: got cs=%h xfer=%h busy=%h want 0",
               a_cstart, a_xfer, a_busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_idle !== 1'b1 || a_ready !== 1'b0) begin
        failures++;
        $display("FAIL start_held_over_reset: got idle=%b ready=%b want 1/0",
                 a_idle, a_ready);
      end
    end
    a_start = 1'b0;
    step();
  endtask

  task automatic test_full_mask();
    a_num = 32'd16384; a_en = 4'hF; a_start = 1'b1;
    step();
    checks++;
    if (a_ready !== 1'b1 || a_cstart !== 4'hF || a_idle !== 1'b0) begin
      failures++;
      $display("FAIL full_launch: got ready=%b cs=%h idle=%b want 1/f/0",
               a_ready, a_cstart, a_idle);
    end
    checks++;
    if (a_xfer !== 32'd16384) begin
      failures++;
      $display("FAIL full_xfer: got %0d want 16384", a_xfer);
    end
    a_start = 1'b0; a_en = 4'h0; a_num = 32'd7;
    step();
    checks++;
    if (a_ready !== 1'b0 || a_cstart !== '0 || a_busy !== '0 || a_tmo !== 1'b0) begin
      failures++;
      $display("FAIL full_run_entry: got ready=%b cs=%h busy=%0d tmo=%b want 0/0/0/0",
               a_ready, a_cstart, a_busy, a_tmo);
    end
    a_cdone = 4'b0111;
    step();
    a_cdone = 4'b0000;
    step();
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL full_partial: got done=%b want 0", a_done);
    end
    a_cdone = 4'b1000;
    step();
    a_cdone = 4'b0000;
    checks++;
    if (a_done !== 1'b1 || a_busy !== CW'(3)) begin
      failures++;
      $display("FAIL full_done: got done=%b busy=%0d want 1/3", a_done, a_busy);
    end
    step();
    checks++;
    if (a_done !== 1'b0 || a_idle !== 1'b1 || a_xfer !== 32'd16384) begin
      failures++;
      $display("FAIL full_after: got done=%b idle=%b xfer=%0d want 0/1/16384",
               a_done, a_idle, a_xfer);
    end
  endtask

  task automatic test_sparse_mask();
    a_cdone = 4'b0010;
    step();
    a_cdone = 4'b0000;
    checks++;
    if (a_idle !== 1'b1 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL sparse_idle_done: got idle=%b done=%b want 1/0", a_idle, a_done);
    end
    a_en = 4'b0101; a_num = 32'd512; a_start = 1'b1;
    step();
    checks++;
    if (a_cstart !== 4'b0101) begin
      failures++;
      $display("FAIL sparse_cstart: got %b want 0101", a_cstart);
    end
    a_start = 1'b0;
    step();
    a_cdone = 4'b0001;
    step();
    a_cdone = 4'b0000;
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL sparse_half: got done=%b want 0", a_done);
    end
    a_cdone = 4'b0100;
    step();
    a_cdone = 4'b0000;
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL sparse_done: got done=%b want 1", a_done);
    end
    step();
  endtask

  task automatic test_random();
    int sched[N];
    int last;
    logic [N-1:0] en;
    logic [XW-1:0] num;
    logic [N-1:0] pulse;
    for (int it = 0; it < 20; it++) begin
      en = N'($urandom);
      num = $urandom;
      last = 1;
      for (int i = 0; i < N; i++) begin
        sched[i] = $urandom_range(1, 8);
        if (en[i] && sched[i] > last) last = sched[i];
      end
      a_en = en; a_num = num; a_start = 1'b1;
      step();
      checks++;
      if (a_ready !== 1'b1 || a_cstart !== en || a_xfer !== num) begin
        failures++;
        $display("FAIL rand_launch it=%0d: got ready=%b cs=%h xfer=%h want 1/%h/%h",
                 it, a_ready, a_cstart, a_xfer, en, num);
      end
      a_start = 1'b0;
      a_en = N'($urandom);
      a_cdone = N'($urandom);
      step();
      for (int c = 1; c <= last; c++) begin
        pulse = '0;
        for (int i = 0; i < N; i++) pulse[i] = (sched[i] == c);
        a_cdone = pulse;
        step();
        a_cdone = '0;
        if (c < last) begin
          checks++;
          if (a_done !== 1'b0) begin
            failures++;
            $display("FAIL rand_early it=%0d c=%0d: got done=%b want 0",
                     it, c, a_done);
          end
        end else begin
          checks++;
          if (a_done !== 1'b1 || a_busy !== CW'(last)) begin
            failures++;
            $display("FAIL rand_done it=%0d: got done=%b busy=%0d want 1/%0d",
                     it, a_done, a_busy, last);
          end
        end
      end
      step();
      checks++;
      if (a_idle !== 1'b1 || a_busy !== CW'(last)) begin
        failures++;
        $display("FAIL rand_idle it=%0d: got idle=%b busy=%0d want 1/%0d",
                 it, a_idle, a_busy, last);
      end
    end
  endtask

  task automatic test_timeout();
    a_en = 4'hF; a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    repeat (99) step();
    checks++;
    if (a_done !== 1'b0 || a_tmo !== 1'b0 || a_busy !== CW'(99)) begin
      failures++;
      $display("FAIL tmo_before: got done=%b tmo=%b busy=%0d want 0/0/99",
               a_done, a_tmo, a_busy);
    end
    step();
    checks++;
    if (a_done !== 1'b1 || a_tmo !== 1'b1 || a_busy !== CW'(100)) begin
      failures++;
      $display("FAIL tmo_fire: got done=%b tmo=%b busy=%0d want 1/1/100",
               a_done, a_tmo, a_busy);
    end
    step();
    checks++;
    if (a_idle !== 1'b1 || a_tmo !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky: got idle=%b tmo=%b want 1/1", a_idle, a_tmo);
    end
    a_en = 4'h0; a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    checks++;
    if (a_tmo !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear: got %b want 0", a_tmo);
    end
    step();
    checks++;
    if (a_done !== 1'b1 || a_busy !== CW'(1)) begin
      failures++;
      $display("FAIL zero_mask: got done=%b busy=%0d want 1/1", a_done, a_busy);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int rdy = 0;
    a_en = 4'b0001; a_start = 1'b1;
    step(); if (a_ready) rdy++;
    a_start = 1'b0;
    step(); if (a_ready) rdy++;
    a_start = 1'b1;
    step(); if (a_ready) rdy++;
    a_start = 1'b0;
    step(); if (a_ready) rdy++;
    a_start = 1'b1;
    a_cdone = 4'b0001;
    step(); if (a_ready) rdy++;
    a_cdone = 4'b0000;
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: got %b want 1", a_done);
    end
    for (int i = 0; i < 4; i++) begin
      step(); if (a_ready) rdy++;
    end
    checks++;
    if (rdy !== 1 || a_idle !== 1'b1) begin
      failures++;
      $display("FAIL b2b_single_ready: got ready_count=%0d idle=%b want 1/1",
               rdy, a_idle);
    end
    a_start = 1'b0; a_en = 4'h0;
    step();
    a_start = 1'b1;
    step();
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: got ready=%b want 1", a_ready);
    end
    a_start = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_chain();
    b_cont = 1'b0; b_en = 4'h0; b_num = 32'd99; b_start = 1'b1;
    step();
    b_start = 1'b0;
    step();
    step();
    checks++;
    if (b_done !== 1'b1) begin
      failures++;
      $display("FAIL chain_done: got %b want 1", b_done);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (b_done !== 1'b1 || b_idle !== 1'b0) begin
        failures++;
        $display("FAIL chain_hold c=%0d: got done=%b idle=%b want 1/0",
                 i, b_done, b_idle);
      end
    end
    b_cont = 1'b1;
    step();
    checks++;
    if (b_idle !== 1'b1 || b_done !== 1'b0) begin
      failures++;
      $display("FAIL chain_release: got idle=%b done=%b want 1/0", b_idle, b_done);
    end
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    step();
    step();
    checks++;
    if (b_done !== 1'b1) begin
      failures++;
      $display("FAIL chain_cont_done: got %b want 1", b_done);
    end
    step();
    checks++;
    if (b_idle !== 1'b1 || b_done !== 1'b0) begin
      failures++;
      $display("FAIL chain_cont_exit: got idle=%b done=%b want 1/0", b_idle, b_done);
    end
  endtask

  task automatic test_reset_midrun();
    int saw_done = 0;
    a_en = 4'hF; a_num = 32'd4096; a_start = 1'b1;
    step();
    a_start = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    a_cdone = 4'hF;
    #1;
    checks++;
    if ({a_idle, a_ready, a_done, a_tmo} !== 4'b1000 || a_cstart !== '0 ||
        a_xfer !== '0 || a_busy !== '0) begin
      failures++;
      $display("FAIL midrun_reset: got flags=%b cs=%h xfer=%h busy=%h want 1000/0/0/0",
               {a_idle, a_ready, a_done, a_tmo}, a_cstart, a_xfer, a_busy);
    end
    for (int i = 0; i < 3; i++) begin
      step(); if (a_done) saw_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); if (a_done) saw_done++;
    end
    a_cdone = 4'h0;
    checks++;
    if (saw_done !== 0 || a_idle !== 1'b1) begin
      failures++;
      $display("FAIL midrun_no_done: got done_cycles=%0d idle=%b want 0/1",
               saw_done, a_idle);
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_random();
    test_timeout();
    test_back_to_back();
    test_chain();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
